spi_slave_param: RTL and testbench
==================================

# spi_slave_param

Parametrised SPI slave front-end for the RAM subsystem, sitting between the external SPI pins and the synchronous RAM. It deserialises fixed-length command frames of `PAYLOAD_W+2` bits from MOSI into `rx_data` and pulses `rx_valid` once per completed frame. For read-data commands it waits for RAM data on a `tx_valid` handshake and serialises it onto MISO. Unlike the previous generation, it has width parameters, a TX-ready handshake, abort detection on early `SS_n` release, and command-consistency checking.

## Interface
- `PAYLOAD_W`, default 8: payload bits per frame; must be ≥ 2. `FRAME_W = PAYLOAD_W+2`.
- `clk` in 1: single system clock; MOSI/SS_n sampled on rising edge, one bit per cycle.
- `rst` in 1: asynchronous, active-high reset.
- `SS_n` in 1: slave select, active low.
- `MOSI` in 1: serial data in, MSB first.
- `tx_data` in PAYLOAD_W: read data from RAM.
- `tx_valid` in 1: `tx_data` valid; accepted only when `tx_ready`=1.
- `tx_ready` out 1: high while in TX_WAIT.
- `MISO` out 1: serial data out, MSB first; 0 when not shifting.
- `rx_data` out FRAME_W: last completed frame; `[FRAME_W-1:FRAME_W-2]` is the command, rest is payload.
- `rx_valid` out 1: one-cycle pulse per completed, accepted frame.
- `frame_err` out 1: one-cycle pulse when SS_n rises before a frame or TX completes.
- `cmd_err` out 1: one-cycle pulse when a completed frame's command contradicts the read route.

## Operation
- Commands: 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, WAIT_SS (3-bit encoding).
- IDLE: `SS_n`=0 → CHK_CMD. No bit is sampled in IDLE.
- CHK_CMD: samples frame bit FRAME_W-1 into the shift register.
  - MOSI=0 → WRITE.
  - MOSI=1 and `addr_seen`=0 → READ_ADD.
  - MOSI=1 and `addr_seen`=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift one bit per cycle. `bit_cnt` width is `$clog2(FRAME_W+1)`.
- On the edge that samples bit 0 (FRAME_W bits total, including the CHK_CMD bit):
  - `rx_data` is loaded; it changes only here.
  - `rx_valid` is 1 for exactly one cycle.
- Command check on completion:
  - READ_ADD must carry 10 and READ_DATA must carry 11.
  - On mismatch: `cmd_err` pulses instead of `rx_valid`, `rx_data` is not updated, `addr_seen` is unchanged, next state is WAIT_SS.
- Next state after a good completion: WRITE → WAIT_SS; READ_ADD → WAIT_SS with `addr_seen`←1; READ_DATA → TX_WAIT with `addr_seen`←0.
- TX_WAIT: `tx_ready`=1. `tx_valid`=1 latches `tx_data` → TX_SHIFT. `tx_valid` in any other state is ignored.
- TX_SHIFT: MISO drives latched bits PAYLOAD_W-1 down to 0, one per cycle, then → WAIT_SS.
- WAIT_SS: MOSI ignored; `SS_n`=1 → IDLE.
- SS_n=1 in CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT or TX_SHIFT:
  - next state IDLE, `frame_err` pulses, no `rx_valid`.
  - `addr_seen` keeps its value from before the aborted frame.
- SS_n=1 on the same edge that samples bit 0: abort wins. No `rx_valid`, `frame_err` pulses.

## Timing
- Reset values: all outputs 0, state IDLE, `addr_seen`=0, counters 0, shift/TX registers 0. Reset applies mid-frame or mid-TX with no error pulse.
- SS_n falls at edge E0 → CHK_CMD in E0+1 → bit 0 sampled at edge E0+FRAME_W. `rx_valid` is high in the cycle after that edge.
- `tx_valid` accepted at edge T → MISO=bit PAYLOAD_W-1 in cycle T+1 → last bit in cycle T+PAYLOAD_W → MISO=0 in cycle T+PAYLOAD_W+1.
- All outputs are registered. `tx_ready` may be decoded from the state register.
- `frame_err` and `cmd_err` never assert in the same cycle as `rx_valid`.

## Structure
- Shared package `spi_pkg` holds:
  - state enum `spi_state_t`;
  - command constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`;
  - FRAME_W derivation helper.
- One sub-module is natural: `spi_tx_shifter`, a PAYLOAD_W load/shift register with MISO output and done flag.
- The RX shift register, FSM and flags stay in the top module.

## Test plan
- PAYLOAD_W=8, send 00_1010_0101 → `rx_data`=0x0A5 with one `rx_valid` pulse, no errors, then `SS_n`↑ → IDLE.
- Send 10_0000_0111, release `SS_n`, then send 11_xxxx_xxxx → `rx_valid` both times. `tx_ready`↑, hold `tx_valid`=0 for 5 cycles, then `tx_data`=0xC3 → MISO 1,1,0,0,0,0,1,1; `addr_seen`=0 afterwards.
- Raise `SS_n` after 6 bits of a write frame → `frame_err` pulse, `rx_data` unchanged, no `rx_valid`.
- After a read address (`addr_seen`=1), send 10_0000_0001 (routed to READ_DATA) → `cmd_err` pulse, no `rx_valid`, `addr_seen` stays 1, FSM sits in WAIT_SS.
- Assert `rst` during TX_SHIFT bit 3 → MISO=0 and state IDLE immediately, no `frame_err`, next frame routes to READ_ADD.
- PAYLOAD_W=14: full write frame → `rx_valid` exactly 16 cycles after entering CHK_CMD.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end: FSM state encoding,
// the two-bit command codes, and the frame-width derivation.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    TX_WAIT   = 3'd5,
    TX_SHIFT  = 3'd6,
    WAIT_SS   = 3'd7
  } spi_state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // A frame is the payload plus the two command bits in front of it.
  function automatic int frame_w(input int payload_w);
    return payload_w + 2;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser for read data. Loading drives the
// MSB on MISO in the very next cycle; the remaining bits follow one per
// cycle while shift_en is high, after which MISO returns to 0.
// done is high while the last bit is on MISO.
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic                 clr,
  input  logic [PAYLOAD_W-1:0] load_data,
  output logic                 miso,
  output logic                 done
);

  localparam int CNT_W = (PAYLOAD_W > 2) ? $clog2(PAYLOAD_W) : 1;

  logic [PAYLOAD_W-1:0] data_reg;
  logic [PAYLOAD_W-1:0] data_shifted;
  logic [PAYLOAD_W-1:0] load_shifted;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 miso_reg;
  logic                 busy_reg;

  // One-position shift toward the MSB for both the held word and the
  // word being loaded (its MSB goes straight to MISO).
  assign data_shifted[0] = 1'b0;
  assign load_shifted[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < PAYLOAD_W; gi++) begin : g_shift
      assign data_shifted[gi] = data_reg[gi-1];
      assign load_shifted[gi] = load_data[gi-1];
    end
  endgenerate

  assign miso = miso_reg;
  assign done = busy_reg && (cnt_reg == '0);

  // Load/shift register; cnt_reg counts bits still to come after the one on MISO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      cnt_reg  <= '0;
      miso_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else if (clr) begin
      data_reg <= '0;
      cnt_reg  <= '0;
      miso_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else if (load) begin
      miso_reg <= load_data[PAYLOAD_W-1];
      data_reg <= load_shifted;
      cnt_reg  <= CNT_W'(PAYLOAD_W-1);
      busy_reg <= 1'b1;
    end else if (shift_en && busy_reg) begin
      if (cnt_reg == '0) begin
        miso_reg <= 1'b0;
        busy_reg <= 1'b0;
      end else begin
        miso_reg <= data_reg[PAYLOAD_W-1];
        data_reg <= data_shifted;
        cnt_reg  <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the RAM subsystem. Collects FRAME_W-bit command
// frames from MOSI, checks the command against the read route, hands good
// frames to the RAM side, and serialises read data from the RAM onto MISO.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SS_n,
  input  logic                     MOSI,
  input  logic [PAYLOAD_W-1:0]     tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     MISO,
  output logic [PAYLOAD_W+1:0]     rx_data,
  output logic                     rx_valid,
  output logic                     frame_err,
  output logic                     cmd_err
);

  localparam int FRAME_W = frame_w(PAYLOAD_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  spi_state_t state_reg, state_next;

  // Bits already received in this frame; the incoming MOSI bit completes it.
  logic [FRAME_W-2:0] shift_reg, shift_next;
  logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [FRAME_W-1:0] rx_data_reg, rx_data_next;
  logic               rx_valid_reg, rx_valid_next;
  logic               frame_err_reg, frame_err_next;
  logic               cmd_err_reg, cmd_err_next;
  logic               addr_seen_reg, addr_seen_next;

  logic [FRAME_W-1:0] frame_in;
  logic [1:0]         frame_cmd;
  logic               cmd_ok;
  logic               last_bit;
  logic               tx_load;
  logic               tx_clr;
  logic               tx_done;

  assign frame_in  = {shift_reg, MOSI};
  assign frame_cmd = frame_in[FRAME_W-1 -: 2];
  assign last_bit  = (bit_cnt_reg == CNT_W'(FRAME_W-1));

  // A read route must carry the matching read command; writes accept either write code.
  always_comb begin
    cmd_ok = 1'b0;
    case (state_reg)
      WRITE:     cmd_ok = (frame_cmd == CMD_WR_ADDR) || (frame_cmd == CMD_WR_DATA);
      READ_ADD:  cmd_ok = (frame_cmd == CMD_RD_ADDR);
      READ_DATA: cmd_ok = (frame_cmd == CMD_RD_DATA);
      default:   cmd_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, datapath and flag logic; an SS_n release always takes priority.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    cmd_err_next   = 1'b0;
    addr_seen_next = addr_seen_reg;
    tx_load        = 1'b0;
    tx_clr         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!SS_n) begin
          state_next   = CHK_CMD;
          bit_cnt_next = '0;
        end
      end

      CHK_CMD: begin
        if (SS_n) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
          bit_cnt_next   = '0;
        end else begin
          shift_next   = {{(FRAME_W-2){1'b0}}, MOSI};
          bit_cnt_next = CNT_W'(1);
          if (!MOSI) begin
            state_next = WRITE;
          end else if (addr_seen_reg) begin
            state_next = READ_DATA;
          end else begin
            state_next = READ_ADD;
          end
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
          bit_cnt_next   = '0;
        end else begin
          shift_next = frame_in[FRAME_W-2:0];
          if (last_bit) begin
            bit_cnt_next = '0;
            if (cmd_ok) begin
              rx_data_next  = frame_in;
              rx_valid_next = 1'b1;
              if (state_reg == READ_DATA) begin
                state_next     = TX_WAIT;
                addr_seen_next = 1'b0;
              end else begin
                state_next = WAIT_SS;
                if (state_reg == READ_ADD) begin
                  addr_seen_next = 1'b1;
                end
              end
            end else begin
              cmd_err_next = 1'b1;
              state_next   = WAIT_SS;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      TX_WAIT: begin
        if (SS_n) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
        end else if (tx_valid) begin
          tx_load    = 1'b1;
          state_next = TX_SHIFT;
        end
      end

      TX_SHIFT: begin
        if (SS_n) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
          tx_clr         = 1'b1;
        end else if (tx_done) begin
          state_next = WAIT_SS;
        end
      end

      WAIT_SS: begin
        if (SS_n) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Receive datapath and one-cycle status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      cmd_err_reg   <= 1'b0;
      addr_seen_reg <= 1'b0;
    end else begin
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
      cmd_err_reg   <= cmd_err_next;
      addr_seen_reg <= addr_seen_next;
    end
  end

  spi_tx_shifter #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_tx_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .shift_en (state_reg == TX_SHIFT),
    .clr      (tx_clr),
    .load_data(tx_data),
    .miso     (MISO),
    .done     (tx_done)
  );

  assign tx_ready  = (state_reg == TX_WAIT);
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param at PAYLOAD_W=8 and PAYLOAD_W=14.
module tb_spi_slave_param;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ss8 = 1'b1, mosi8 = 1'b0;
  logic [7:0]  tx_data8 = '0;
  logic        tx_valid8 = 1'b0;
  logic        tx_ready8, miso8, rx_valid8, frame_err8, cmd_err8;
  logic [9:0]  rx_data8;

  logic        ss14 = 1'b1, mosi14 = 1'b0;
  logic [13:0] tx_data14 = '0;
  logic        tx_valid14 = 1'b0;
  logic        tx_ready14, miso14, rx_valid14, frame_err14, cmd_err14;
  logic [15:0] rx_data14;

  int total = 0;
  int bad   = 0;
  int n_rxv = 0, n_ferr = 0, n_cerr = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.PAYLOAD_W(8)) u8 (
    .clk(clk), .rst(rst), .SS_n(ss8), .MOSI(mosi8),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .MISO(miso8), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .frame_err(frame_err8), .cmd_err(cmd_err8)
  );

  spi_slave_param #(.PAYLOAD_W(14)) u14 (
    .clk(clk), .rst(rst), .SS_n(ss14), .MOSI(mosi14),
    .tx_data(tx_data14), .tx_valid(tx_valid14), .tx_ready(tx_ready14),
    .MISO(miso14), .rx_data(rx_data14), .rx_valid(rx_valid14),
    .frame_err(frame_err14), .cmd_err(cmd_err14)
  );

  // Pulse counters for the 8-bit instance, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (rx_valid8)  n_rxv++;
    if (frame_err8) n_ferr++;
    if (cmd_err8)   n_cerr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full frame, MSB first; returns at the falling edge where rx_valid should show.
  task automatic frame8(input logic [9:0] f);
    $display("frame8 %03h", f);
    ss8 = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      mosi8 = f[i];
    end
    @(negedge clk);
  endtask

  task automatic release8();
    ss8   = 1'b1;
    mosi8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // First nb bits of a frame, then SS_n released; returns where frame_err should show.
  task automatic partial8(input logic [9:0] f, input int nb);
    $display("partial8 %03h bits=%0d", f, nb);
    ss8 = 1'b0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      mosi8 = f[9-i];
    end
    @(negedge clk);
    ss8 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int rv0, fe0, ce0;
    logic [7:0]  exp_bits;
    logic [15:0] f14;
    int n, t_chk, t_rv;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso8), 32'd0);
    chk("rst_rx_data", 32'(rx_data8), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid8), 32'd0);
    chk("rst_errs", 32'({frame_err8, cmd_err8}), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready8), 32'd0);
    chk("rst_state", 32'(u8.state_reg), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Write-address frame
    rv0 = n_rxv; fe0 = n_ferr; ce0 = n_cerr;
    frame8(10'h0A5);
    chk("wr_rx_valid", 32'(rx_valid8), 32'd1);
    chk("wr_rx_data", 32'(rx_data8), 32'h0A5);
    chk("wr_state", 32'(u8.state_reg), 32'(WAIT_SS));
    tx_valid8 = 1'b1; tx_data8 = 8'hFF;
    @(negedge clk);
    tx_valid8 = 1'b0;
    chk("wr_txv_ignored_miso", 32'(miso8), 32'd0);
    chk("wr_txv_ignored_state", 32'(u8.state_reg), 32'(WAIT_SS));
    release8();
    chk("wr_idle", 32'(u8.state_reg), 32'(IDLE));
    chk("wr_rxv_count", 32'(n_rxv - rv0), 32'd1);
    chk("wr_err_count", 32'((n_ferr - fe0) + (n_cerr - ce0)), 32'd0);

    // Read address then read data, with delayed RAM response
    rv0 = n_rxv;
    frame8(10'h207);
    chk("ra_rx_data", 32'(rx_data8), 32'h207);
    chk("ra_addr_seen", 32'(u8.addr_seen_reg), 32'd1);
    release8();
    frame8(10'h35A);
    chk("rd_rx_valid", 32'(rx_valid8), 32'd1);
    chk("rd_rx_data", 32'(rx_data8), 32'h35A);
    chk("rd_tx_ready", 32'(tx_ready8), 32'd1);
    chk("rd_addr_seen", 32'(u8.addr_seen_reg), 32'd0);
    chk("rd_rxv_count", 32'(n_rxv - rv0), 32'd2);
    repeat (5) @(negedge clk);
    chk("rd_wait_ready", 32'(tx_ready8), 32'd1);
    chk("rd_wait_miso", 32'(miso8), 32'd0);
    exp_bits = 8'hC3;
    tx_data8 = 8'hC3; tx_valid8 = 1'b1;
    $display("tx8 %02h", tx_data8);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) tx_valid8 = 1'b0;
      chk($sformatf("tx_bit%0d", 7 - k), 32'(miso8), 32'(exp_bits[7-k]));
      if (k == 3) chk("tx_shift_ready", 32'(tx_ready8), 32'd0);
    end
    @(negedge clk);
    chk("tx_end_miso", 32'(miso8), 32'd0);
    chk("tx_end_state", 32'(u8.state_reg), 32'(WAIT_SS));
    chk("tx_end_addr_seen", 32'(u8.addr_seen_reg), 32'd0);
    release8();

    // Aborted write frame
    rv0 = n_rxv; fe0 = n_ferr;
    partial8(10'h0F0, 6);
    chk("ab_frame_err", 32'(frame_err8), 32'd1);
    chk("ab_state", 32'(u8.state_reg), 32'(IDLE));
    @(negedge clk);
    chk("ab_rx_data", 32'(rx_data8), 32'h35A);
    chk("ab_rxv_count", 32'(n_rxv - rv0), 32'd0);
    chk("ab_ferr_count", 32'(n_ferr - fe0), 32'd1);

    // Read-address command arriving on the read-data route
    frame8(10'h201);
    chk("ce_setup_addr_seen", 32'(u8.addr_seen_reg), 32'd1);
    release8();
    rv0 = n_rxv; ce0 = n_cerr;
    frame8(10'h201);
    chk("ce_cmd_err", 32'(cmd_err8), 32'd1);
    chk("ce_rx_valid", 32'(rx_valid8), 32'd0);
    chk("ce_rx_data", 32'(rx_data8), 32'h201);
    chk("ce_addr_seen", 32'(u8.addr_seen_reg), 32'd1);
    chk("ce_state", 32'(u8.state_reg), 32'(WAIT_SS));
    chk("ce_counts", 32'({n_rxv - rv0, n_cerr - ce0}), 32'({32'd0, 32'd1}));
    release8();

    // Reset while bit 3 is on MISO
    fe0 = n_ferr;
    frame8(10'h300);
    chk("rs_tx_ready", 32'(tx_ready8), 32'd1);
    tx_data8 = 8'h0F; tx_valid8 = 1'b1;
    $display("tx8 %02h (reset at bit 3)", tx_data8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) tx_valid8 = 1'b0;
    end
    chk("rs_bit3_before", 32'(miso8), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_miso", 32'(miso8), 32'd0);
    chk("rs_state", 32'(u8.state_reg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0; ss8 = 1'b1;
    @(negedge clk);
    chk("rs_no_ferr", 32'(n_ferr - fe0), 32'd0);
    rv0 = n_rxv; ce0 = n_cerr;
    frame8(10'h255);
    chk("rs_next_rx_valid", 32'(rx_valid8), 32'd1);
    chk("rs_next_rx_data", 32'(rx_data8), 32'h255);
    chk("rs_next_addr_seen", 32'(u8.addr_seen_reg), 32'd1);
    chk("rs_next_cerr", 32'(n_cerr - ce0), 32'd0);
    release8();

    // PAYLOAD_W=14 latency: rx_valid 16 cycles after entering CHK_CMD
    f14 = 16'h1ABC;
    $display("frame14 %04h", f14);
    n = 0; t_chk = -1; t_rv = -1;
    ss14 = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      n++;
      if (t_chk < 0 && u14.state_reg == CHK_CMD) t_chk = n;
      mosi14 = f14[i];
    end
    for (int w = 0; w < 8 && t_rv < 0; w++) begin
      @(negedge clk);
      n++;
      if (rx_valid14) t_rv = n;
    end
    chk("w14_seen_rx_valid", 32'(t_rv > 0), 32'd1);
    chk("w14_latency", 32'(t_rv - t_chk), 32'd16);
    chk("w14_rx_data", 32'(rx_data14), 32'h1ABC);
    chk("w14_errs", 32'({frame_err14, cmd_err14}), 32'd0);
    ss14 = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
